// File: rtl/hps_i2c_pkg.sv
// hps_i2c_pkg: shared state encoding and I2C bus constants for the fabric-side I2C target
package hps_i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
  } i2c_state_e;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   RW_BIT   = 0;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and derives edge and START/STOP pulses
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_q, scl_d, sda_q, sda_d;
  logic scl_p_q, sda_p_q, scl_s;
  always_comb begin
    scl_d = {scl_q[SYNC_STAGES-2:0], scl_in};
    sda_d = {sda_q[SYNC_STAGES-2:0], sda_in};
  end
  // Idle bus level is high, so reset the chains high to avoid a false START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q   <= '1;
      sda_q   <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  end
  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start    = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop     = scl_s & scl_p_q & ~sda_p_q & sda_s;
endmodule

// File: rtl/hps_i2c_target_regs.sv
// hps_i2c_target_regs: I2C target exposing NUM_REGS byte registers with auto-incrementing pointer
module hps_i2c_target_regs
  import hps_i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h55,
  parameter int         NUM_REGS    = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic [NUM_REGS*8-1:0]       reg_q,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic [7:0]                  wr_data,
  output logic                        busy
);
  localparam int PW = $clog2(NUM_REGS);
  logic sda_s, scl_rise, scl_fall, start, stop;
  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, wr_data_q, wr_data_d, byte_in, rd_cur, rd_next;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, wr_index_q, wr_index_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_clk), .rst(reset_reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign byte_in = {sh_q[6:0], sda_s};
  assign ptr_inc = ptr_q + 1'b1;
  assign rd_cur  = regs_q[{ptr_q, 3'b000} +: 8];
  assign rd_next = regs_q[{ptr_inc, 3'b000} +: 8];
  // In ACK states cnt_q marks whether the 9th SCL rise has been seen.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    if (stop) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                state_d = byte_in[7:1] == TARGET_ADDR ? ST_ADDR_ACK : ST_WAIT_STOP;
                busy_d  = byte_in[7:1] == TARGET_ADDR;
              end else if (state_q == ST_PTR) begin
                ptr_d   = byte_in[PW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                regs_d[{ptr_q, 3'b000} +: 8] = byte_in;
                wr_strobe_d = 1'b1;
                wr_index_d  = ptr_q;
                wr_data_d   = byte_in;
                ptr_d       = ptr_inc;
                state_d     = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) cnt_d = 3'd1;
          if (scl_fall && cnt_q == 3'd0) sda_oe_d = ~I2C_ACK;
          if (scl_fall && cnt_q == 3'd1) begin
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            state_d  = state_q == ST_ADDR_ACK ? ST_PTR : ST_WDATA;
            if (state_q == ST_ADDR_ACK && sh_q[RW_BIT]) begin
              state_d  = ST_RDATA;
              sh_d     = rd_cur;
              sda_oe_d = ~rd_cur[7];
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d   = cnt_q + 3'd1;
            state_d = cnt_q == 3'd7 ? ST_RDATA_ACK : ST_RDATA;
          end
          if (scl_fall) begin
            sh_d     = {sh_q[6:0], 1'b0};
            sda_oe_d = ~sh_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall && cnt_q == 3'd0) sda_oe_d = 1'b0;
          if (scl_rise) begin
            cnt_d   = 3'd1;
            sh_d[0] = sda_s;
          end
          if (scl_fall && cnt_q == 3'd1) begin
            cnt_d = 3'd0;
            if (sh_q[0] == I2C_NACK) state_d = ST_WAIT_STOP;
            else begin
              state_d  = ST_RDATA;
              ptr_d    = ptr_inc;
              sh_d     = rd_next;
              sda_oe_d = ~rd_next[7];
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= '0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign wr_data   = wr_data_q;
  assign reg_q     = regs_q;
endmodule
